// File: rtl/svm_row_pkg.sv
// Shared constants and types for the SVM row-slice engine.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package svm_row_pkg;
  localparam int DWIDTH    = 8;
  localparam int CWIDTH    = 9;
  localparam int BLOCKSIZE = 8;
  localparam int WPI       = 8;
  localparam int WINCOLS   = 8;
  localparam int WINROWS   = 16;

  localparam int WINW   = BLOCKSIZE * WINCOLS;
  localparam int ROWLEN = WINW * WPI;
  localparam int NWIN   = WPI * WINCOLS;
  localparam int NPIX   = ROWLEN * WINROWS;
  localparam int NCOEF  = NPIX / WPI;
  localparam int ACCW   = 32;
  localparam int PRODW  = DWIDTH + CWIDTH + 1;

  // ring bank depth (two rows) and coefficient buffer depth
  localparam int BDEPTH = 2 * BLOCKSIZE;
  localparam int CDEPTH = 2 * WINW;

  localparam int CNTW = $clog2(NPIX + 1);
  localparam int KW   = $clog2(NCOEF + 1);
  localparam int WCW  = $clog2(WPI);
  localparam int BKW  = $clog2(NWIN);
  localparam int BAW  = $clog2(BDEPTH);
  localparam int CAW  = $clog2(CDEPTH);
  localparam int XBW  = $clog2(WINCOLS);

  typedef logic        [DWIDTH-1:0] pix_t;
  typedef logic signed [CWIDTH-1:0] coef_t;
  typedef logic signed [ACCW-1:0]   acc_t;
  typedef logic signed [PRODW-1:0]  prod_t;
endpackage

// File: rtl/svm_row_if.sv
// Pixel/coefficient stream in, window result burst out.
// Latency: n/a (wiring only).
// Backpressure: none; the source suspends the stream with dvi_bypass.
interface svm_row_if;
  import svm_row_pkg::*;

  pix_t           data;
  logic           dvi_in;
  logic           dvi_bypass;
  coef_t          svcoeff_in;
  coef_t          svcoeff_out;
  logic [WCW-1:0] wincount;
  logic           download;
  logic           done;
  acc_t           svm_data;
  logic           dvo;

  modport master (
    output data, dvi_in, dvi_bypass, svcoeff_in,
    input  svcoeff_out, wincount, download, done, svm_data, dvo
  );

  modport slave (
    input  data, dvi_in, dvi_bypass, svcoeff_in,
    output svcoeff_out, wincount, download, done, svm_data, dvo
  );
endinterface

// File: rtl/svm_row_pixbuf.sv
// Two-row pixel ring split into NWIN banks, one write port, one read port per bank.
// Latency: read data registered, valid one cycle after the address.
// Backpressure: none; writes and reads happen every cycle they are presented.
module svm_row_pixbuf
  import svm_row_pkg::*;
(
  input  logic           clk,
  input  logic           reset_n,
  input  logic           wr_en,
  input  logic [BKW-1:0] wr_bank,
  input  logic [BAW-1:0] wr_addr,
  input  pix_t           wr_dat,
  input  logic [BAW-1:0] rd_addr [NWIN],
  output pix_t           rd_dat  [NWIN]
);
  pix_t mem [NWIN][BDEPTH];

  // store accepted pixels and read one entry from every bank each cycle
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int b = 0; b < NWIN; b++) begin
        rd_dat[b] <= '0;
        for (int a = 0; a < BDEPTH; a++) mem[b][a] <= '0;
      end
    end else begin
      if (wr_en) mem[wr_bank][wr_addr] <= wr_dat;
      for (int b = 0; b < NWIN; b++) rd_dat[b] <= mem[b][rd_addr[b]];
    end
  end
endmodule

// File: rtl/svm_row_mem.sv
// Streaming SVM row slice: NWIN parallel window dot-products over one pixel frame.
// Latency: download at most WINW+4 cycles after the last pixel, then an NWIN-cycle burst.
// Backpressure: never stalls input; pixels past a full frame are dropped until done.
module svm_row_mem
  import svm_row_pkg::*;
(
  input logic       clk,
  input logic       reset_n,
  svm_row_if.slave  bus
);
  localparam logic [1:0] S_RUN = 2'd0;
  localparam logic [1:0] S_DL  = 2'd1;
  localparam logic [1:0] S_OUT = 2'd2;
  localparam logic [1:0] S_FIN = 2'd3;

  logic [1:0]      state;
  logic [CNTW-1:0] pix_cnt;
  logic [KW-1:0]   coef_cnt;
  logic [KW-1:0]   step_k;
  logic [WCW-1:0]  wincount;
  coef_t           coef_mem [CDEPTH];
  coef_t           coef_rd;
  coef_t           coef_last;
  logic            s1_vld;
  logic            s1_last;
  logic            s1_lastrow;
  logic [XBW-1:0]  s1_xb;
  acc_t            acc [NWIN];
  logic [BKW-1:0]  out_cnt;
  logic            download;
  logic            done;
  logic            dvo;
  acc_t            svm_data;

  logic            frame_full;
  logic            accept;
  logic            step_rdy;
  logic            frame_end;
  logic [31:0]     step_y;
  logic [31:0]     step_x;
  logic [31:0]     step_need;
  logic [XBW-1:0]  step_xb;
  logic [BKW-1:0]  wr_bank;
  logic [BAW-1:0]  wr_addr;
  logic [BAW-1:0]  rd_addr [NWIN];
  pix_t            rd_dat  [NWIN];
  pix_t            rot_dat [NWIN];
  prod_t           prod    [NWIN];

  assign frame_full = (pix_cnt == CNTW'(NPIX));
  assign accept     = bus.dvi_in && !bus.dvi_bypass && !frame_full;
  assign frame_end  = (state == S_FIN);
  assign wr_bank    = BKW'((32'(pix_cnt) / BLOCKSIZE) % NWIN);
  assign wr_addr    = BAW'(32'(pix_cnt) % BLOCKSIZE + BLOCKSIZE * ((32'(pix_cnt) / ROWLEN) % 2));

  // decode step k into window row/column and the last pixel position it touches
  always_comb begin
    step_y    = 32'(step_k) / WINW;
    step_x    = 32'(step_k) % WINW;
    step_xb   = XBW'(step_x / BLOCKSIZE);
    step_need = step_y * ROWLEN + step_x + BLOCKSIZE * (NWIN - 1);
  end

  // a step may run once its coefficient is stored and its furthest pixel has landed
  assign step_rdy = (state == S_RUN) && (step_k != KW'(NCOEF)) && (coef_cnt > step_k) &&
                    (frame_full || (32'(pix_cnt) > step_need));

  // banks below the block offset hold the next row's copy of this step's pixel
  always_comb begin
    for (int b = 0; b < NWIN; b++) begin
      rd_addr[b] = BAW'(step_x % BLOCKSIZE +
                        BLOCKSIZE * ((step_y + ((b < int'(step_xb)) ? 32'd1 : 32'd0)) % 2));
    end
  end

  svm_row_pixbuf u_pixbuf (
    .clk     (clk),
    .reset_n (reset_n),
    .wr_en   (accept),
    .wr_bank (wr_bank),
    .wr_addr (wr_addr),
    .wr_dat  (bus.data),
    .rd_addr (rd_addr),
    .rd_dat  (rd_dat)
  );

  // count accepted pixels and capture one coefficient at each wincount wrap
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pix_cnt   <= '0;
      wincount  <= '0;
      coef_cnt  <= '0;
      coef_last <= '0;
      for (int i = 0; i < CDEPTH; i++) coef_mem[i] <= '0;
    end else if (frame_end) begin
      pix_cnt  <= '0;
      wincount <= '0;
      coef_cnt <= '0;
    end else if (accept) begin
      pix_cnt  <= pix_cnt + CNTW'(1);
      wincount <= (wincount == WCW'(WPI - 1)) ? '0 : wincount + WCW'(1);
      if (wincount == '0) begin
        coef_mem[CAW'(32'(coef_cnt) % CDEPTH)] <= bus.svcoeff_in;
        coef_cnt  <= coef_cnt + KW'(1);
        coef_last <= bus.svcoeff_in;
      end
    end
  end

  // issue one step per clock, carrying its coefficient alongside the bank reads
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      step_k     <= '0;
      s1_vld     <= 1'b0;
      s1_last    <= 1'b0;
      s1_lastrow <= 1'b0;
      s1_xb      <= '0;
      coef_rd    <= '0;
    end else if (frame_end) begin
      step_k  <= '0;
      s1_vld  <= 1'b0;
      s1_last <= 1'b0;
    end else begin
      s1_vld     <= step_rdy;
      s1_last    <= step_rdy && (step_k == KW'(NCOEF - 1));
      s1_lastrow <= (step_y == 32'(WINROWS - 1));
      s1_xb      <= step_xb;
      coef_rd    <= coef_mem[CAW'(32'(step_k) % CDEPTH)];
      if (step_rdy) step_k <= step_k + KW'(1);
    end
  end

  // route each bank to its window and mask positions past the end of the frame
  always_comb begin
    for (int w = 0; w < NWIN; w++) begin
      rot_dat[w] = rd_dat[BKW'((int'(s1_xb) + w) % NWIN)];
      prod[w]    = '0;
      if (!(s1_lastrow && (int'(s1_xb) + w >= NWIN)))
        prod[w] = prod_t'($signed({1'b0, rot_dat[w]})) * prod_t'(coef_rd);
    end
  end

  // accumulate retired steps, then shift the accumulators out as the result burst
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state    <= S_RUN;
      out_cnt  <= '0;
      download <= 1'b0;
      done     <= 1'b0;
      dvo      <= 1'b0;
      svm_data <= '0;
      for (int w = 0; w < NWIN; w++) acc[w] <= '0;
    end else begin
      case (state)
        S_RUN: begin
          if (s1_vld)
            for (int w = 0; w < NWIN; w++) acc[w] <= acc[w] + ACCW'(prod[w]);
          if (s1_last) begin
            state    <= S_DL;
            download <= 1'b1;
          end
        end
        S_DL, S_OUT: begin
          download <= 1'b0;
          dvo      <= 1'b1;
          svm_data <= acc[0];
          for (int w = 0; w < NWIN - 1; w++) acc[w] <= acc[w+1];
          acc[NWIN-1] <= '0;
          out_cnt <= out_cnt + BKW'(1);
          done    <= (out_cnt == BKW'(NWIN - 1));
          state   <= (out_cnt == BKW'(NWIN - 1)) ? S_FIN : S_OUT;
        end
        default: begin
          dvo     <= 1'b0;
          done    <= 1'b0;
          out_cnt <= '0;
          state   <= S_RUN;
          for (int w = 0; w < NWIN; w++) acc[w] <= '0;
        end
      endcase
    end
  end

  assign bus.svcoeff_out = coef_last;
  assign bus.wincount    = wincount;
  assign bus.download    = download;
  assign bus.done        = done;
  assign bus.dvo         = dvo;
  assign bus.svm_data    = svm_data;
endmodule

// File: tb/tb_svm_row_mem.sv
// Randomized bench for svm_row_mem with a frame-level reference model.
module tb_svm_row_mem;
  import svm_row_pkg::*;

  logic clk = 1'b0;
  logic reset_n;
  svm_row_if bus();

  svm_row_mem dut (.clk(clk), .reset_n(reset_n), .bus(bus));

  always #5 clk = ~clk;

  int    checks = 0;
  int    failures = 0;
  pix_t  m_pix  [NPIX];
  coef_t m_coef [NCOEF];
  coef_t m_svout;
  int    m_cnt;
  int    exp_r [NWIN];
  int    got_r [NWIN];
  bit    in_burst, seen_dl, late_flag, burst_end;
  int    bidx, since_full;
  int    frames_done = 0;

  function automatic void chk(string nm, logic signed [31:0] act, logic signed [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", nm, act, req);
    end
  endfunction

  // results straight from the window definition over the captured frame
  function automatic void compute_exp();
    for (int w = 0; w < NWIN; w++) begin
      int s;
      s = 0;
      for (int y = 0; y < WINROWS; y++)
        for (int x = 0; x < WINW; x++) begin
          int q;
          q = y * ROWLEN + x + BLOCKSIZE * w;
          if (q < NPIX) s += int'(m_pix[q]) * int'(m_coef[y * WINW + x]);
        end
      exp_r[w] = s;
    end
  endfunction

  // per-cycle compare against the model, then fold the inputs of the coming edge into it
  always @(negedge clk) begin
    if (!reset_n) begin
      chk("reset_dvo", bus.dvo, 0);
      chk("reset_download", bus.download, 0);
      chk("reset_done", bus.done, 0);
      chk("reset_svm_data", bus.svm_data, 0);
      chk("reset_wincount", bus.wincount, 0);
      chk("reset_svcoeff_out", bus.svcoeff_out, 0);
      m_cnt = 0; m_svout = '0; in_burst = 0; seen_dl = 0;
      late_flag = 0; since_full = 0; bidx = 0;
    end else begin
      burst_end = 0;
      chk("wincount", bus.wincount, m_cnt % WPI);
      chk("svcoeff_out", bus.svcoeff_out, m_svout);
      if (in_burst) begin
        chk("dvo_burst", bus.dvo, 1);
        chk("download_burst", bus.download, 0);
        chk($sformatf("svm_data[%0d]", bidx), bus.svm_data, exp_r[bidx]);
        chk("done", bus.done, bidx == NWIN - 1);
        got_r[bidx] = bus.svm_data;
        bidx++;
        if (bidx == NWIN) begin in_burst = 0; burst_end = 1; end
      end else begin
        chk("dvo_idle", bus.dvo, 0);
        chk("done_idle", bus.done, 0);
        if (m_cnt == NPIX && !seen_dl) since_full++;
        if (bus.download) begin
          chk("download_frame_full", m_cnt == NPIX, 1);
          checks++;
          if (since_full > WINW + 5) begin
            failures++;
            $display("FAIL download_latency: got %0d cycles limit %0d", since_full - 1, WINW + 4);
          end
          compute_exp();
          in_burst = 1; bidx = 0; seen_dl = 1;
        end else if (m_cnt == NPIX && !late_flag && since_full > WINW + 5) begin
          checks++; failures++; late_flag = 1;
          $display("FAIL download_timeout: none after %0d cycles limit %0d", since_full - 1, WINW + 4);
        end
      end
      if (bus.dvi_in && !bus.dvi_bypass && m_cnt < NPIX) begin
        if (m_cnt % WPI == 0) begin
          m_coef[m_cnt / WPI] = bus.svcoeff_in;
          m_svout = bus.svcoeff_in;
        end
        m_pix[m_cnt] = bus.data;
        m_cnt++;
      end
      if (burst_end) begin
        m_cnt = 0; seen_dl = 0; since_full = 0; late_flag = 0;
        frames_done++;
      end
    end
  end

  function automatic pix_t pix_val(int mode, int p);
    case (mode)
      0:       return pix_t'(1);
      1:       return pix_t'(255);
      2:       return (p == 8) ? pix_t'(10) : pix_t'(0);
      default: return pix_t'($urandom_range(99));
    endcase
  endfunction

  function automatic coef_t coef_val(int mode, int k);
    case (mode)
      0:       return coef_t'(1);
      1:       return coef_t'(-256);
      2:       return (k == 0) ? coef_t'(3) : coef_t'(0);
      default: return coef_t'(int'($urandom_range(198)) - 99);
    endcase
  endfunction

  // present stop_at pixels; idle cycles carry ignored pulses under dvi_bypass
  task automatic drive_pixels(int mode, bit random_duty, int stop_at);
    int p;
    p = 0;
    while (p < stop_at) begin
      @(posedge clk); #1;
      if (!random_duty || $urandom_range(1) == 1) begin
        bus.dvi_in = 1'b1;
        bus.dvi_bypass = 1'b0;
        bus.data = pix_val(mode, p);
        bus.svcoeff_in = (p % WPI == 0) ? coef_val(mode, p / WPI) : coef_t'($urandom_range(511));
        p++;
      end else begin
        bus.dvi_bypass = 1'($urandom_range(1));
        bus.dvi_in = bus.dvi_bypass;
        bus.data = pix_t'($urandom_range(255));
        bus.svcoeff_in = coef_t'($urandom_range(511));
      end
    end
  endtask

  task automatic run_frame(int mode, bit random_duty);
    int prev, n;
    prev = frames_done;
    drive_pixels(mode, random_duty, NPIX);
    n = 0;
    @(posedge clk); #1;
    bus.dvi_bypass = 1'b1;
    while (frames_done == prev && n < 400) begin
      @(posedge clk); #1;
      bus.dvi_in = 1'($urandom_range(1));
      bus.data = pix_t'($urandom_range(255));
      n++;
    end
    if (frames_done == prev) begin
      checks++; failures++;
      $display("FAIL burst_timeout: got no burst expected one within %0d cycles", 400);
    end
    bus.dvi_bypass = 1'b0;
    bus.dvi_in = 1'b0;
  endtask

  initial begin
    reset_n = 1'b0;
    bus.data = '0; bus.dvi_in = 1'b0; bus.dvi_bypass = 1'b0; bus.svcoeff_in = '0;
    repeat (3) @(posedge clk);
    #1 reset_n = 1'b1;

    run_frame(0, 1'b0);
    chk("ones_r0", got_r[0], 1024);
    chk("ones_r56", got_r[56], 1024);
    chk("ones_r57", got_r[57], 1016);
    chk("ones_r63", got_r[63], 968);
    chk("model_ones_r63", exp_r[63], 968);

    run_frame(1, 1'b0);
    chk("max_r0", got_r[0], -66846720);
    chk("max_r63", got_r[63], -63191040);

    run_frame(2, 1'b0);
    chk("single_r0", got_r[0], 0);
    chk("single_r1", got_r[1], 30);
    chk("single_r2", got_r[2], 0);
    chk("model_single_r1", exp_r[1], 30);

    run_frame(3, 1'b1);

    drive_pixels(3, 1'b0, 2000);
    @(posedge clk); #1;
    reset_n = 1'b0;
    bus.dvi_in = 1'b0;
    repeat (3) @(posedge clk);
    #1 reset_n = 1'b1;

    run_frame(3, 1'b1);
    chk("frames_done", frames_done, 5);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
